// File: rtl/dualport_ram_sweepclear_pkg.sv
// Shared constants for the sweep-clear dual-port RAM: sweep FSM encoding and default geometry.
package dualport_ram_sweepclear_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } sweep_state_e;

    localparam int DEF_ADDRLEN       = 10;
    localparam int DEF_DATALEN       = 2;
    localparam int DEF_DEPTH         = 1024;
    localparam int DEF_CLR_PER_CYCLE = 4;

    // Counter/index width that never collapses to zero bits for tiny sizes.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/dualport_ram_sweepclear_if.sv
// Bus bundle for the sweep-clear dual-port RAM: both access ports plus the clear handshake.
interface dualport_ram_sweepclear_if
    import dualport_ram_sweepclear_pkg::*;
#(
    parameter int ADDRLEN = DEF_ADDRLEN,
    parameter int DATALEN = DEF_DATALEN
) ();

    logic [ADDRLEN-1:0] addra;
    logic [DATALEN-1:0] wdataa;
    logic               wea;
    logic [DATALEN-1:0] rdataa;
    logic [ADDRLEN-1:0] addrb;
    logic [DATALEN-1:0] wdatab;
    logic               web;
    logic [DATALEN-1:0] rdatab;
    logic               clear;
    logic               busy;
    logic               clear_done;

    modport master (
        output addra, wdataa, wea, addrb, wdatab, web, clear,
        input  rdataa, rdatab, busy, clear_done
    );

    modport slave (
        input  addra, wdataa, wea, addrb, wdatab, web, clear,
        output rdataa, rdatab, busy, clear_done
    );

endinterface

// File: rtl/dualport_ram_sweepclear_ram_sweep_ctrl.sv
// Sweep-clear sequencer: walks the entry groups one per cycle and raises busy / clear_done.
module ram_sweep_ctrl
    import dualport_ram_sweepclear_pkg::*;
#(
    parameter int GROUPS = DEF_DEPTH / DEF_CLR_PER_CYCLE,
    parameter int GW     = 8
) (
    input  logic          clk,
    input  logic          reset_x,
    input  logic          clear,
    output logic          sweep_active,
    output logic [GW-1:0] group_idx,
    output logic          busy,
    output logic          clear_done
);

    localparam logic [GW-1:0] LAST_GROUP = GW'(GROUPS - 1);

    sweep_state_e  state_q, state_d;
    logic [GW-1:0] count_q, count_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // A clear seen mid-sweep rewinds to group 0 without signalling completion.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear) begin
                    state_d = SWEEP;
                    count_d = '0;
                end
            end
            SWEEP: begin
                if (clear) begin
                    count_d = '0;
                end else if (count_q == LAST_GROUP) begin
                    state_d = IDLE;
                    count_d = '0;
                    done_d  = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == SWEEP);
    end

    always_ff @(posedge clk) begin
        if (!reset_x) begin
            state_q <= IDLE;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sweep_active = (state_q == SWEEP);
    assign group_idx    = count_q;
    assign busy         = busy_q;
    assign clear_done   = done_q;

endmodule

// File: rtl/dualport_ram_sweepclear.sv
// Two-port synchronous table RAM with multi-cycle sweep clear.
// Optional write-first forwarding when DPRAM_BYPASS_EN is defined; read-first otherwise.
module dualport_ram_sweepclear
    import dualport_ram_sweepclear_pkg::*;
#(
    parameter int ADDRLEN       = DEF_ADDRLEN,
    parameter int DATALEN       = DEF_DATALEN,
    parameter int DEPTH         = DEF_DEPTH,
    parameter int CLR_PER_CYCLE = DEF_CLR_PER_CYCLE
) (
    input  logic                      clk,
    input  logic                      reset_x,
    dualport_ram_sweepclear_if.slave  bus
);

    localparam int IDXW   = clog2_min1(DEPTH);
    localparam int GROUPS = DEPTH / CLR_PER_CYCLE;
    localparam int GW     = clog2_min1(GROUPS);
    localparam int CSHIFT = $clog2(CLR_PER_CYCLE);
    localparam logic [ADDRLEN:0] DEPTH_W = (ADDRLEN + 1)'(DEPTH);

    logic [DATALEN-1:0] mem [DEPTH];

    logic               sweep_active;
    logic [GW-1:0]      group_idx;
    logic               busy;
    logic               clear_done;
    logic               in_range_a, in_range_b;
    logic               write_a, write_b;
    logic [IDXW-1:0]    idx_a, idx_b;
    logic [IDXW-1:0]    sweep_base;
    logic [DATALEN-1:0] rdataa_q, rdataa_d;
    logic [DATALEN-1:0] rdatab_q, rdatab_d;

    ram_sweep_ctrl #(
        .GROUPS (GROUPS),
        .GW     (GW)
    ) u_sweep_ctrl (
        .clk          (clk),
        .reset_x      (reset_x),
        .clear        (bus.clear),
        .sweep_active (sweep_active),
        .group_idx    (group_idx),
        .busy         (busy),
        .clear_done   (clear_done)
    );

    assign in_range_a = ({1'b0, bus.addra} < DEPTH_W);
    assign in_range_b = ({1'b0, bus.addrb} < DEPTH_W);
    assign idx_a      = bus.addra[IDXW-1:0];
    assign idx_b      = bus.addrb[IDXW-1:0];
    assign write_a    = bus.wea & in_range_a & ~sweep_active;
    assign write_b    = bus.web & in_range_b & ~sweep_active;
    assign sweep_base = IDXW'(group_idx) << CSHIFT;

    // Sole driver of the array. Port B is written last so it wins a same-address collision;
    // a reset edge aborts the sweep before it zeroes another group.
    always_ff @(posedge clk) begin
        if (sweep_active) begin
            if (reset_x) begin
                for (int k = 0; k < CLR_PER_CYCLE; k++) begin
                    mem[sweep_base + IDXW'(k)] <= '0;
                end
            end
        end else begin
            if (write_a) begin
                mem[idx_a] <= bus.wdataa;
            end
            if (write_b) begin
                mem[idx_b] <= bus.wdatab;
            end
        end
    end

    always_comb begin
        rdataa_d = '0;
        rdatab_d = '0;
        if (!sweep_active) begin
            if (in_range_a) begin
                rdataa_d = mem[idx_a];
`ifdef DPRAM_BYPASS_EN
                if (write_b && idx_b == idx_a) begin
                    rdataa_d = bus.wdatab;
                end else if (write_a) begin
                    rdataa_d = bus.wdataa;
                end
`endif
            end
            if (in_range_b) begin
                rdatab_d = mem[idx_b];
`ifdef DPRAM_BYPASS_EN
                if (write_b) begin
                    rdatab_d = bus.wdatab;
                end else if (write_a && idx_a == idx_b) begin
                    rdatab_d = bus.wdataa;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_x) begin
            rdataa_q <= '0;
            rdatab_q <= '0;
        end else begin
            rdataa_q <= rdataa_d;
            rdatab_q <= rdatab_d;
        end
    end

    assign bus.rdataa     = rdataa_q;
    assign bus.rdatab     = rdatab_q;
    assign bus.busy       = busy;
    assign bus.clear_done = clear_done;

endmodule

// File: tb/tb_dualport_ram_sweepclear.sv
// Directed testbench for dualport_ram_sweepclear: a 16-entry instance and a 12-entry out-of-range instance.
module tb_dualport_ram_sweepclear;

`ifdef DPRAM_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_x = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dualport_ram_sweepclear_if #(.ADDRLEN(5), .DATALEN(2)) bus ();
    dualport_ram_sweepclear_if #(.ADDRLEN(4), .DATALEN(2)) bus_o ();

    dualport_ram_sweepclear #(
        .ADDRLEN(5), .DATALEN(2), .DEPTH(16), .CLR_PER_CYCLE(4)
    ) u_dut (
        .clk     (clk),
        .reset_x (reset_x),
        .bus     (bus)
    );

    dualport_ram_sweepclear #(
        .ADDRLEN(4), .DATALEN(2), .DEPTH(12), .CLR_PER_CYCLE(4)
    ) u_oor (
        .clk     (clk),
        .reset_x (reset_x),
        .bus     (bus_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.addra = '0; bus.wdataa = '0; bus.wea = 1'b0;
        bus.addrb = '0; bus.wdatab = '0; bus.web = 1'b0;
        bus.clear = 1'b0;
        bus_o.addra = '0; bus_o.wdataa = '0; bus_o.wea = 1'b0;
        bus_o.addrb = '0; bus_o.wdatab = '0; bus_o.web = 1'b0;
        bus_o.clear = 1'b0;
    endtask

    task automatic fill(input logic [1:0] value);
        for (int i = 0; i < 8; i++) begin
            bus.addra = 5'(2 * i);
            bus.addrb = 5'(2 * i + 1);
            bus.wdataa = value;
            bus.wdatab = value;
            bus.wea = 1'b1;
            bus.web = 1'b1;
            tick();
        end
        bus.wea = 1'b0;
        bus.web = 1'b0;
    endtask

    task automatic test_reset();
        reset_x = 1'b0;
        tick();
        tick();
        checks++; if (bus.rdataa !== 2'd0) begin errors++; $display("[TB] FAIL reset_rdataa got %0d expected 0", bus.rdataa); end
        checks++; if (bus.rdatab !== 2'd0) begin errors++; $display("[TB] FAIL reset_rdatab got %0d expected 0", bus.rdatab); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %0d expected 0", bus.busy); end
        checks++; if (bus.clear_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %0d expected 0", bus.clear_done); end
        checks++; if (bus_o.rdataa !== 2'd0) begin errors++; $display("[TB] FAIL reset_oor_rdataa got %0d expected 0", bus_o.rdataa); end
        checks++; if (bus_o.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_oor_busy got %0d expected 0", bus_o.busy); end
        reset_x = 1'b1;
        tick();
    endtask

    task automatic test_basic_rw();
        bus.addra = 5'd5; bus.wdataa = 2'b11; bus.wea = 1'b1;
        tick();
        bus.wea = 1'b0; bus.addrb = 5'd5;
        tick();
        checks++; if (bus.rdatab !== 2'b11) begin errors++; $display("[TB] FAIL basic_b_read5 got %0d expected 3", bus.rdatab); end
        bus.addrb = 5'd6; bus.wdatab = 2'b10; bus.web = 1'b1;
        tick();
        bus.web = 1'b0; bus.addra = 5'd6;
        tick();
        checks++; if (bus.rdataa !== 2'b10) begin errors++; $display("[TB] FAIL basic_a_read6 got %0d expected 2", bus.rdataa); end
        bus.addra = 5'd5;
        tick();
        checks++; if (bus.rdataa !== 2'b11) begin errors++; $display("[TB] FAIL basic_a_read5 got %0d expected 3", bus.rdataa); end
    endtask

    task automatic test_collision();
        bus.addra = 5'd9; bus.addrb = 5'd9;
        bus.wdataa = 2'd1; bus.wdatab = 2'd2;
        bus.wea = 1'b1; bus.web = 1'b1;
        tick();
        bus.wea = 1'b0; bus.web = 1'b0;
        tick();
        checks++; if (bus.rdataa !== 2'd2) begin errors++; $display("[TB] FAIL collision_a got %0d expected 2", bus.rdataa); end
        checks++; if (bus.rdatab !== 2'd2) begin errors++; $display("[TB] FAIL collision_b got %0d expected 2", bus.rdatab); end
    endtask

    task automatic test_rdw();
        logic [1:0] exp_v;
        bus.addrb = 5'd3; bus.wdatab = 2'd1; bus.web = 1'b1;
        tick();
        bus.web = 1'b0;
        bus.addra = 5'd3; bus.wdataa = 2'd3; bus.wea = 1'b1; bus.addrb = 5'd3;
        tick();
        bus.wea = 1'b0;
        exp_v = BYP ? 2'd3 : 2'd1;
        checks++; if (bus.rdatab !== exp_v) begin errors++; $display("[TB] FAIL rdw_cross got %0d expected %0d", bus.rdatab, exp_v); end
        checks++; if (bus.rdataa !== exp_v) begin errors++; $display("[TB] FAIL rdw_same got %0d expected %0d", bus.rdataa, exp_v); end
        tick();
        checks++; if (bus.rdatab !== 2'd3) begin errors++; $display("[TB] FAIL rdw_after got %0d expected 3", bus.rdatab); end
        bus.addra = 5'd4; bus.wdataa = 2'd0; bus.wea = 1'b1;
        tick();
        bus.addrb = 5'd4; bus.wdataa = 2'd1; bus.wdatab = 2'd2; bus.web = 1'b1;
        tick();
        bus.wea = 1'b0; bus.web = 1'b0;
        exp_v = BYP ? 2'd2 : 2'd0;
        checks++; if (bus.rdataa !== exp_v) begin errors++; $display("[TB] FAIL rdw_dual_a got %0d expected %0d", bus.rdataa, exp_v); end
        checks++; if (bus.rdatab !== exp_v) begin errors++; $display("[TB] FAIL rdw_dual_b got %0d expected %0d", bus.rdatab, exp_v); end
    endtask

    task automatic test_sweep();
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_at = -1;
        fill(2'd3);
        bus.addra = 5'd0;
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.clear_done === 1'b1) begin done_cnt++; done_at = i; end
            if (i >= 1 && i <= 3) begin
                checks++; if (bus.rdataa !== 2'd0) begin errors++; $display("[TB] FAIL sweep_busy_read cycle %0d got %0d expected 0", i, bus.rdataa); end
            end
            bus.addra = 5'd0; bus.wdataa = 2'd3; bus.wea = (i < 4);
            tick();
        end
        bus.wea = 1'b0;
        checks++; if (busy_cnt != 4) begin errors++; $display("[TB] FAIL sweep_busy_len got %0d expected 4", busy_cnt); end
        checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL sweep_done_count got %0d expected 1", done_cnt); end
        checks++; if (done_at != 4) begin errors++; $display("[TB] FAIL sweep_done_pos got %0d expected 4", done_at); end
        for (int j = 0; j < 16; j++) begin
            bus.addra = 5'(j);
            bus.addrb = 5'(15 - j);
            tick();
            checks++; if (bus.rdataa !== 2'd0) begin errors++; $display("[TB] FAIL sweep_zero_a addr %0d got %0d expected 0", j, bus.rdataa); end
            checks++; if (bus.rdatab !== 2'd0) begin errors++; $display("[TB] FAIL sweep_zero_b addr %0d got %0d expected 0", 15 - j, bus.rdatab); end
        end
    endtask

    task automatic test_restart();
        int busy_cnt = 0;
        int done_cnt = 0;
        fill(2'd3);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.clear_done === 1'b1) done_cnt++;
            bus.clear = (i == 1);
            tick();
        end
        bus.clear = 1'b0;
        checks++; if (busy_cnt != 6) begin errors++; $display("[TB] FAIL restart_busy_len got %0d expected 6", busy_cnt); end
        checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL restart_done_count got %0d expected 1", done_cnt); end
        bus.addra = 5'd15;
        tick();
        checks++; if (bus.rdataa !== 2'd0) begin errors++; $display("[TB] FAIL restart_zero15 got %0d expected 0", bus.rdataa); end
    endtask

    task automatic test_reset_mid_sweep();
        int busy_cnt = 0;
        int done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            bus.addra = 5'(4 + 2 * i);
            bus.addrb = 5'(5 + 2 * i);
            bus.wdataa = 2'd2; bus.wdatab = 2'd2;
            bus.wea = 1'b1; bus.web = 1'b1;
            tick();
        end
        bus.wea = 1'b0; bus.web = 1'b0;
        bus.addra = 5'd12;
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        tick();
        tick();
        reset_x = 1'b0;
        tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy got %0d expected 0", bus.busy); end
        checks++; if (bus.rdataa !== 2'd0) begin errors++; $display("[TB] FAIL midreset_rdata got %0d expected 0", bus.rdataa); end
        checks++; if (bus.clear_done !== 1'b0) begin errors++; $display("[TB] FAIL midreset_done got %0d expected 0", bus.clear_done); end
        reset_x = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.clear_done === 1'b1) done_cnt++;
        end
        checks++; if (busy_cnt != 0) begin errors++; $display("[TB] FAIL midreset_idle_busy got %0d expected 0", busy_cnt); end
        checks++; if (done_cnt != 0) begin errors++; $display("[TB] FAIL midreset_idle_done got %0d expected 0", done_cnt); end
        for (int j = 0; j < 4; j++) begin
            bus.addra = 5'(4 + j);
            bus.addrb = 5'(12 + j);
            tick();
            checks++; if (bus.rdataa !== 2'd0) begin errors++; $display("[TB] FAIL midreset_cleared addr %0d got %0d expected 0", 4 + j, bus.rdataa); end
            checks++; if (bus.rdatab !== 2'd2) begin errors++; $display("[TB] FAIL midreset_kept addr %0d got %0d expected 2", 12 + j, bus.rdatab); end
        end
    endtask

    task automatic test_out_of_range();
        bus_o.addra = 4'd2; bus_o.wdataa = 2'd1; bus_o.wea = 1'b1;
        bus_o.addrb = 4'd6; bus_o.wdatab = 2'd1; bus_o.web = 1'b1;
        tick();
        bus_o.addra = 4'd14; bus_o.wdataa = 2'd3;
        bus_o.addrb = 4'd12; bus_o.wdatab = 2'd2;
        tick();
        bus_o.wea = 1'b0; bus_o.web = 1'b0;
        bus_o.addra = 4'd14; bus_o.addrb = 4'd2;
        tick();
        checks++; if (bus_o.rdataa !== 2'd0) begin errors++; $display("[TB] FAIL oor_read14 got %0d expected 0", bus_o.rdataa); end
        checks++; if (bus_o.rdatab !== 2'd1) begin errors++; $display("[TB] FAIL oor_keep2 got %0d expected 1", bus_o.rdatab); end
        bus_o.addra = 4'd6; bus_o.addrb = 4'd12;
        tick();
        checks++; if (bus_o.rdataa !== 2'd1) begin errors++; $display("[TB] FAIL oor_keep6 got %0d expected 1", bus_o.rdataa); end
        checks++; if (bus_o.rdatab !== 2'd0) begin errors++; $display("[TB] FAIL oor_read12 got %0d expected 0", bus_o.rdatab); end
        bus_o.addra = 4'd11; bus_o.wdataa = 2'd2; bus_o.wea = 1'b1;
        tick();
        bus_o.wea = 1'b0;
        tick();
        checks++; if (bus_o.rdataa !== 2'd2) begin errors++; $display("[TB] FAIL oor_last11 got %0d expected 2", bus_o.rdataa); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_basic_rw();
        test_collision();
        test_rdw();
        test_sweep();
        test_restart();
        test_reset_mid_sweep();
        test_out_of_range();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
